// File: rtl/ntt_pkg.sv
// rtl/ntt_pkg.sv - shared parameters, types and bit-reversal helper for the NTT reorder path
package ntt_pkg;

    localparam int DEF_DATA_W = 13;
    localparam int DEF_LOG_N  = 8;
    localparam int MAX_LOG_N  = 12;

    typedef logic                 bank_sel_t;
    typedef logic [DEF_LOG_N-1:0] idx_t;

    // Reverses the low 'width' bits of x; bits above 'width' are returned as zero.
    function automatic logic [MAX_LOG_N-1:0] bitrev(input logic [MAX_LOG_N-1:0] x,
                                                    input int unsigned width);
        logic [MAX_LOG_N-1:0] r;
        for (int i = 0; i < MAX_LOG_N; i++) begin
            r[i] = x[MAX_LOG_N-1-i];
        end
        return r >> (MAX_LOG_N - width);
    endfunction

endpackage

// File: rtl/ntt_pingpong_ram.sv
// rtl/ntt_pingpong_ram.sv - two N x DATA_W banks, one write port, one asynchronous read port
module ntt_pingpong_ram
    import ntt_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int LOG_N  = DEF_LOG_N
) (
    input  logic              clk,
    input  logic              we,
    input  logic              wr_bank,
    input  logic [LOG_N-1:0]  wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_bank,
    input  logic [LOG_N-1:0]  rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam int N = 1 << LOG_N;

    logic [DATA_W-1:0] bank0 [N];
    logic [DATA_W-1:0] bank1 [N];

    always_ff @(posedge clk) begin
        if (we) begin
            if (wr_bank) begin
                bank1[wr_addr] <= wr_data;
            end else begin
                bank0[wr_addr] <= wr_data;
            end
        end
    end

    assign rd_data = rd_bank ? bank1[rd_addr] : bank0[rd_addr];

endmodule

// File: rtl/ntt_bitrev_stream.sv
// rtl/ntt_bitrev_stream.sv - ping-pong streaming reorder buffer emitting bit-reversed or natural frames
module ntt_bitrev_stream
    import ntt_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int LOG_N  = DEF_LOG_N
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_bitrev,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              out_bitrev
);

    localparam logic [LOG_N-1:0] IDX_LAST = '1;

    bank_sel_t         wr_bank;
    bank_sel_t         rd_bank;
    logic [LOG_N-1:0]  wr_cnt;
    logic [LOG_N-1:0]  rd_cnt;
    logic [1:0]        bank_full;
    logic [1:0]        bank_full_nxt;
    logic [1:0]        mode;

    logic              wr_fire;
    logic              rd_fire;
    logic              wr_done;
    logic              rd_done;
    logic [LOG_N-1:0]  rd_rev;
    logic [LOG_N-1:0]  rd_addr;
    logic [DATA_W-1:0] rd_data;

    assign in_ready = !bank_full[wr_bank] && !clear;
    assign wr_fire  = in_valid && in_ready;
    assign rd_fire  = bank_full[rd_bank] && (!out_valid || out_ready) && !clear;
    assign wr_done  = wr_fire && (wr_cnt == IDX_LAST);
    assign rd_done  = rd_fire && (rd_cnt == IDX_LAST);

    assign rd_rev  = LOG_N'(bitrev(MAX_LOG_N'(rd_cnt), LOG_N));
    assign rd_addr = mode[rd_bank] ? rd_rev : rd_cnt;

    // Fill and drain completion always hit different banks, so both edits can apply together.
    always_comb begin
        bank_full_nxt = bank_full;
        if (wr_done) begin
            bank_full_nxt[wr_bank] = 1'b1;
        end
        if (rd_done) begin
            bank_full_nxt[rd_bank] = 1'b0;
        end
    end

    ntt_pingpong_ram #(
        .DATA_W (DATA_W),
        .LOG_N  (LOG_N)
    ) u_ram (
        .clk     (clk),
        .we      (wr_fire),
        .wr_bank (wr_bank),
        .wr_addr (wr_cnt),
        .wr_data (in_data),
        .rd_bank (rd_bank),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_bank    <= 1'b0;
            rd_bank    <= 1'b0;
            wr_cnt     <= '0;
            rd_cnt     <= '0;
            bank_full  <= 2'b00;
            mode       <= 2'b00;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_data   <= '0;
            out_bitrev <= 1'b0;
        end else if (clear) begin
            wr_bank    <= 1'b0;
            rd_bank    <= 1'b0;
            wr_cnt     <= '0;
            rd_cnt     <= '0;
            bank_full  <= 2'b00;
            mode       <= 2'b00;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_data   <= '0;
            out_bitrev <= 1'b0;
        end else begin
            bank_full <= bank_full_nxt;

            if (wr_fire) begin
                if (wr_cnt == '0) begin
                    mode[wr_bank] <= in_bitrev;
                end
                wr_cnt <= wr_cnt + 1'b1;
                if (wr_done) begin
                    wr_bank <= ~wr_bank;
                end
            end

            if (rd_fire) begin
                out_data   <= rd_data;
                out_valid  <= 1'b1;
                out_last   <= (rd_cnt == IDX_LAST);
                out_bitrev <= mode[rd_bank];
                rd_cnt     <= rd_cnt + 1'b1;
                if (rd_done) begin
                    rd_bank <= ~rd_bank;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ntt_bitrev_stream.sv
// tb/tb_ntt_bitrev_stream.sv - randomized self-checking bench with a frame-level reorder model
module tb_ntt_bitrev_stream;

    localparam int DW = 13;
    localparam int LN = 3;
    localparam int NN = 8;

    logic          clk;
    logic          reset;
    logic          clear;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_bitrev;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          out_bitrev;

    ntt_bitrev_stream #(.DATA_W(DW), .LOG_N(LN)) dut (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_bitrev  (in_bitrev),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .out_bitrev (out_bitrev)
    );

    always #5 clk = ~clk;

    int n_tests;
    int n_fail;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        logic          br;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] frame_buf[NN];
    int            fcnt;
    logic          fmode;

    logic          s_ai, s_ao, s_ov, s_ir, s_ol, s_ob;
    logic [DW-1:0] s_od;

    function automatic int rev3(input int i);
        return (i % 2) * 4 + ((i / 2) % 2) * 2 + (i / 4);
    endfunction

    task automatic model_in(input logic [DW-1:0] d, input logic b);
        exp_t e;
        if (fcnt == 0) fmode = b;
        frame_buf[fcnt] = d;
        fcnt++;
        if (fcnt == NN) begin
            for (int i = 0; i < NN; i++) begin
                e.data = frame_buf[fmode ? rev3(i) : i];
                e.last = (i == NN - 1);
                e.br   = fmode;
                exp_q.push_back(e);
            end
            fcnt = 0;
        end
    endtask

    task automatic model_flush();
        fcnt = 0;
        exp_q.delete();
    endtask

    task automatic tick(input logic v, input logic [DW-1:0] d, input logic b,
                        input logic r, input logic c);
        @(negedge clk);
        in_valid = v; in_data = d; in_bitrev = b; out_ready = r; clear = c;
        #1;
        s_ai = in_valid && in_ready;
        s_ao = out_valid && out_ready;
        s_ov = out_valid;
        s_ir = in_ready;
        s_od = out_data; s_ol = out_last; s_ob = out_bitrev;
        @(posedge clk);
        if (s_ai) model_in(d, b);
        if (c) model_flush();
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset out_valid: got %0b want 0", out_valid); end
        n_tests++; if (out_data !== '0) begin n_fail++; $display("FAIL reset out_data: got %0d want 0", out_data); end
        n_tests++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset out_last: got %0b want 0", out_last); end
        n_tests++; if (out_bitrev !== 1'b0) begin n_fail++; $display("FAIL reset out_bitrev: got %0b want 0", out_bitrev); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset in_ready: got %0b want 1", in_ready); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_bitrev_frame();
        int sent = 0, got = 0, t0 = -1, first = -1;
        int tab[NN] = '{0, 4, 2, 6, 1, 5, 3, 7};
        exp_t e;
        for (int cyc = 0; cyc < 60 && got < NN; cyc++) begin
            tick(sent < NN, DW'(sent), 1'b1, 1'b1, 1'b0);
            if (s_ai && sent == 0) t0 = cyc;
            if (s_ai) sent++;
            if (s_ov && first < 0) first = cyc;
            if (s_ao) begin
                n_tests++;
                if (s_od !== DW'(tab[got])) begin n_fail++; $display("FAIL bitrev_order[%0d]: got %0d want %0d", got, s_od, tab[got]); end
                e = exp_q.pop_front();
                n_tests++;
                if ({s_od, s_ol, s_ob} !== {e.data, e.last, e.br}) begin
                    n_fail++; $display("FAIL bitrev_frame: got d=%0d l=%0b b=%0b want d=%0d l=%0b b=%0b", s_od, s_ol, s_ob, e.data, e.last, e.br);
                end
                got++;
            end
        end
        n_tests++; if (first - t0 != NN + 1) begin n_fail++; $display("FAIL bitrev_latency: got %0d ticks want %0d", first - t0, NN + 1); end
        n_tests++; if (got != NN) begin n_fail++; $display("FAIL bitrev_count: got %0d want %0d", got, NN); end
    endtask

    task automatic test_natural();
        int sent = 0, got = 0;
        exp_t e;
        for (int cyc = 0; cyc < 60 && got < NN; cyc++) begin
            tick(sent < NN, DW'(10 + sent), 1'b0, 1'b1, 1'b0);
            if (s_ai) sent++;
            if (s_ao) begin
                n_tests++;
                if (exp_q.size() == 0) begin n_fail++; $display("FAIL natural_extra: got %0d want none", s_od); end
                else begin
                    e = exp_q.pop_front();
                    if ({s_od, s_ol, s_ob} !== {e.data, e.last, e.br}) begin
                        n_fail++; $display("FAIL natural_frame: got d=%0d l=%0b b=%0b want d=%0d l=%0b b=%0b", s_od, s_ol, s_ob, e.data, e.last, e.br);
                    end
                end
                got++;
            end
        end
        n_tests++; if (got != NN) begin n_fail++; $display("FAIL natural_count: got %0d want %0d", got, NN); end
    endtask

    task automatic test_back_to_back();
        int sent = 0, got = 0;
        logic modes[3] = '{1'b1, 1'b0, 1'b1};
        logic ready_drop = 1'b0, gap = 1'b0, started = 1'b0;
        exp_t e;
        for (int cyc = 0; cyc < 100 && got < 3 * NN; cyc++) begin
            tick(sent < 3 * NN, DW'($urandom), (sent < 3 * NN) ? modes[sent / NN] : 1'b0, 1'b1, 1'b0);
            if (sent < 3 * NN && !s_ir) ready_drop = 1'b1;
            if (s_ai) sent++;
            if (started && !s_ov) gap = 1'b1;
            if (s_ao) begin
                started = 1'b1;
                n_tests++;
                if (exp_q.size() == 0) begin n_fail++; $display("FAIL b2b_extra: got %0d want none", s_od); end
                else begin
                    e = exp_q.pop_front();
                    if ({s_od, s_ol, s_ob} !== {e.data, e.last, e.br}) begin
                        n_fail++; $display("FAIL b2b_frame: got d=%0d l=%0b b=%0b want d=%0d l=%0b b=%0b", s_od, s_ol, s_ob, e.data, e.last, e.br);
                    end
                end
                got++;
            end
        end
        n_tests++; if (ready_drop !== 1'b0) begin n_fail++; $display("FAIL b2b_in_ready: dropped=%0b want 0", ready_drop); end
        n_tests++; if (gap !== 1'b0) begin n_fail++; $display("FAIL b2b_gap: gap=%0b want 0", gap); end
        n_tests++; if (got != 3 * NN) begin n_fail++; $display("FAIL b2b_count: got %0d want %0d", got, 3 * NN); end
    endtask

    task automatic test_backpressure();
        int sent = 0, got = 0, stall = 0;
        logic r, prev_hold = 1'b0, saw_not_ready = 1'b0;
        logic [DW+1:0] prev = '0;
        exp_t e;
        for (int cyc = 0; cyc < 200 && got < 3 * NN; cyc++) begin
            r = !(got >= 2 && stall < 20);
            tick(sent < 3 * NN, DW'($urandom), 1'($urandom), r, 1'b0);
            if (!r) stall++;
            if (sent < 3 * NN && !s_ir) saw_not_ready = 1'b1;
            if (s_ai) sent++;
            if (prev_hold) begin
                n_tests++;
                if ({s_od, s_ol, s_ob} !== prev) begin n_fail++; $display("FAIL bp_hold: got %0h want %0h", {s_od, s_ol, s_ob}, prev); end
            end
            prev_hold = s_ov && !r;
            prev = {s_od, s_ol, s_ob};
            if (s_ao) begin
                n_tests++;
                if (exp_q.size() == 0) begin n_fail++; $display("FAIL bp_extra: got %0d want none", s_od); end
                else begin
                    e = exp_q.pop_front();
                    if ({s_od, s_ol, s_ob} !== {e.data, e.last, e.br}) begin
                        n_fail++; $display("FAIL bp_frame: got d=%0d l=%0b b=%0b want d=%0d l=%0b b=%0b", s_od, s_ol, s_ob, e.data, e.last, e.br);
                    end
                end
                got++;
            end
        end
        n_tests++; if (saw_not_ready !== 1'b1) begin n_fail++; $display("FAIL bp_in_ready: saw_low=%0b want 1", saw_not_ready); end
        n_tests++; if (got != 3 * NN || exp_q.size() != 0) begin n_fail++; $display("FAIL bp_count: got %0d left %0d want %0d left 0", got, exp_q.size(), 3 * NN); end
    endtask

    task automatic test_reset_mid();
        int sent = 0, got = 0;
        exp_t e;
        for (int cyc = 0; cyc < 40 && sent < NN + 5; cyc++) begin
            tick(1'b1, DW'($urandom_range(1, 8191)), 1'b1, 1'b0, 1'b0);
            if (s_ai) sent++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        model_flush();
        n_tests++;
        if ({out_valid, out_data, out_last, out_bitrev} !== '0) begin
            n_fail++; $display("FAIL rstmid_outputs: got v=%0b d=%0d l=%0b b=%0b want all 0", out_valid, out_data, out_last, out_bitrev);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_ready: got %0b want 1", in_ready); end
        sent = 0;
        for (int cyc = 0; cyc < 60 && got < NN; cyc++) begin
            tick(sent < NN, DW'(sent), 1'b1, 1'b1, 1'b0);
            if (s_ai) sent++;
            if (s_ao) begin
                n_tests++;
                if (exp_q.size() == 0) begin n_fail++; $display("FAIL rstmid_extra: got %0d want none", s_od); end
                else begin
                    e = exp_q.pop_front();
                    if ({s_od, s_ol, s_ob} !== {e.data, e.last, e.br}) begin
                        n_fail++; $display("FAIL rstmid_frame: got d=%0d l=%0b b=%0b want d=%0d l=%0b b=%0b", s_od, s_ol, s_ob, e.data, e.last, e.br);
                    end
                end
                got++;
            end
        end
        n_tests++; if (got != NN) begin n_fail++; $display("FAIL rstmid_count: got %0d want %0d", got, NN); end
    endtask

    task automatic test_clear();
        int sent = 0, got = 0;
        exp_t e;
        for (int cyc = 0; cyc < 40 && sent < NN + 3; cyc++) begin
            tick(1'b1, DW'($urandom), 1'($urandom), 1'b0, 1'b0);
            if (s_ai) sent++;
        end
        tick(1'b1, DW'($urandom), 1'b0, 1'b1, 1'b1);
        n_tests++; if (s_ai !== 1'b0) begin n_fail++; $display("FAIL clear_accept: got %0b want 0", s_ai); end
        tick(1'b0, '0, 1'b0, 1'b1, 1'b0);
        n_tests++; if (s_ov !== 1'b0) begin n_fail++; $display("FAIL clear_out_valid: got %0b want 0", s_ov); end
        n_tests++; if (dut.bank_full !== 2'b00) begin n_fail++; $display("FAIL clear_bank_full: got %b want 00", dut.bank_full); end
        n_tests++; if (s_ir !== 1'b1) begin n_fail++; $display("FAIL clear_in_ready: got %0b want 1", s_ir); end
        sent = 0;
        for (int cyc = 0; cyc < 60 && got < NN; cyc++) begin
            tick(sent < NN, DW'($urandom), 1'b1, 1'b1, 1'b0);
            if (s_ai) sent++;
            if (s_ao) begin
                n_tests++;
                if (exp_q.size() == 0) begin n_fail++; $display("FAIL clear_extra: got %0d want none", s_od); end
                else begin
                    e = exp_q.pop_front();
                    if ({s_od, s_ol, s_ob} !== {e.data, e.last, e.br}) begin
                        n_fail++; $display("FAIL clear_frame: got d=%0d l=%0b b=%0b want d=%0d l=%0b b=%0b", s_od, s_ol, s_ob, e.data, e.last, e.br);
                    end
                end
                got++;
            end
        end
        n_tests++; if (got != NN) begin n_fail++; $display("FAIL clear_count: got %0d want %0d", got, NN); end
    endtask

    initial begin
        clk = 1'b0; reset = 1'b1; clear = 1'b0;
        in_valid = 1'b0; in_data = '0; in_bitrev = 1'b0; out_ready = 1'b0;
        n_tests = 0; n_fail = 0; fcnt = 0; fmode = 1'b0;
        test_reset();
        test_bitrev_frame();
        test_natural();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_clear();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ntt_bitrev_stream.md
Name: ntt_bitrev_stream

Overview:
- Parametrised streaming bit-reversal reorder buffer for the NTT datapath; next generation of the single-frame bit_reverse unit.
- Accepts coefficients in natural order over a valid/ready handshake and emits them in bit-reversed or natural order, selectable per frame.
- Uses ping-pong banks, so one frame is written while the previous frame drains; sits between the coefficient source and the PE/controller pipeline.

Parameters:
- DATA_W, 13: coefficient width; matches `DATA_SIZE_ARB.
- LOG_N, 8: log2 of ring size. N = 2**LOG_N coefficients per frame. Legal range 2..12.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous abort; discards both banks and any partial frame.
- in_valid  in  1  input sample valid.
- in_ready  out  1  buffer can accept a sample.
- in_data  in  DATA_W  coefficient, natural order.
- in_bitrev  in  1  order mode; sampled with element 0 of each frame (1 = bit-reversed output, 0 = natural output).
- out_valid  out  1  output register holds a valid sample.
- out_ready  in  1  downstream accepts the sample.
- out_data  out  DATA_W  reordered coefficient.
- out_last  out  1  marks the final sample (index N-1) of an output frame.
- out_bitrev  out  1  mode that applied to the current output frame.

Behaviour:
- Reset state, when reset is asserted or on clear: wr_bank=0, rd_bank=0, wr_cnt=0, rd_cnt=0, bank_full=2'b00, out_valid=0, out_last=0, out_data=0, out_bitrev=0. A partial or pending frame is discarded. The same values apply when reset is asserted mid-frame.
- Write side:
  - in_ready = !bank_full[wr_bank] && !clear.
  - On in_valid && in_ready: mem[wr_bank][wr_cnt] <= in_data; wr_cnt++.
  - When wr_cnt==0, in_bitrev is latched into mode[wr_bank].
  - When wr_cnt==N-1: bank_full[wr_bank] <= 1; wr_bank toggles; wr_cnt <= 0.
- Read side:
  - rd_fire = bank_full[rd_bank] && (!out_valid || out_ready).
  - Read address = mode[rd_bank] ? bitrev(rd_cnt) : rd_cnt, where bitrev reverses the LOG_N bits.
  - On rd_fire: out_data <= mem[rd_bank][addr]; out_valid <= 1; out_last <= (rd_cnt==N-1); out_bitrev <= mode[rd_bank]; rd_cnt++.
  - When rd_cnt==N-1 on rd_fire: bank_full[rd_bank] <= 0; rd_bank toggles; rd_cnt <= 0.
  - If out_valid && out_ready && !rd_fire: out_valid <= 0.
- Backpressure: while out_valid && !out_ready, out_data, out_last and out_bitrev are held stable and rd_cnt does not advance.
- Latency: with no stalls, element 0 accepted at edge t is presented after edge t+N. Output then streams at 1 sample/cycle.
- Throughput: continuous 1 sample/cycle in and out once steady state is reached.
- in_ready deasserts only when both banks are full.
- Simultaneous fill-complete and drain-complete always target different banks, since write only fills a non-full bank and read only drains a full one. Both updates apply in the same cycle.
- Counters wrap exactly at N-1. No partial frames are emitted.
- clear has priority over all handshake activity in the same cycle. reset has priority over clear.
- Memory write/read of the same bank never coincide. No read-during-write hazard exists.

Decomposition:
- Package ntt_pkg:
  - DATA_W and LOG_N defaults.
  - function bitrev(logic [LOG_N-1:0]).
  - typedef bank_sel_t (1 bit).
  - typedef idx_t (LOG_N bits).
- Sub-module ntt_pingpong_ram:
  - Two banks of N x DATA_W.
  - One write port (bank, addr, data, we) and one asynchronous read port (bank, addr).
  - The output register lives in ntt_bitrev_stream.

Test Plan (LOG_N=3, N=8, DATA_W=13):
- Bit-reversed frame: in_bitrev=1, inputs 0..7 with out_ready=1 -> outputs 0,4,2,6,1,5,3,7; out_last only on 7; first out_valid 8 edges after element 0.
- Natural frame: in_bitrev=0, inputs 10..17 -> outputs 10..17 in order; out_bitrev=0.
- Back-to-back: three frames with continuous in_valid, first mode 1, second mode 0, third mode 1, out_ready=1 -> in_ready never drops; each frame is ordered per its own mode; no gap between output frames.
- Backpressure: out_ready=0 for 20 cycles during frame 1 -> out_data stays at its value; in_ready drops after frame 2 fills; no loss or duplication after release.
- Reset mid-frame: reset pulse after 5 inputs -> all outputs 0, in_ready=1 next cycle; new frame 0..7 outputs correctly with no stale data.
- Clear: clear asserted while one bank is full and one is partial -> out_valid=0 and bank_full=00 next cycle; a subsequent frame is reordered correctly.
